// File: rtl/imem_loader_if.sv
// Byte-stream handshake in, instruction-memory write port out.
interface imem_loader_if #(
    parameter int ADDR_W = 9
);
    logic              i_byte_valid;
    logic [7:0]        i_byte;
    logic              o_byte_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;

    modport master (
        output i_byte_valid, i_byte,
        input  o_byte_ready, o_imem_we, o_imem_addr, o_imem_wdata
    );

    modport slave (
        input  i_byte_valid, i_byte,
        output o_byte_ready, o_imem_we, o_imem_addr, o_imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian words written into
// the instruction ROM, holding the core in reset until the program is in place.
module imem_loader #(
    parameter int ROM_SIZE = 512,
    parameter int ADDR_W   = $clog2(ROM_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          o_core_rst,
    output logic          o_done,
    output logic          o_err
);
    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   last_q, last_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              rdy;
    logic              hs;
    logic [15:0]       n_full;

    assign rdy = ~rst & (state_q == S_LEN0 || state_q == S_LEN1 || state_q == S_DATA);
    assign hs  = bus.i_byte_valid & rdy;
    assign n_full = {bus.i_byte, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        last_d     = last_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        wbuf_d     = wbuf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_LEN0: if (hs) begin
                len_lo_d = bus.i_byte;
                state_d  = S_LEN1;
            end
            S_LEN1: if (hs) begin
                if (n_full == 16'd0 || n_full > 16'(ROM_SIZE)) begin
                    state_d = S_ERR;
                end else begin
                    // N is range-checked above, so N-1 always fits the counter width.
                    last_d  = (ADDR_W+1)'(n_full - 16'd1);
                    state_d = S_DATA;
                end
            end
            S_DATA: if (hs) begin
                wbuf_d     = {bus.i_byte, wbuf_q[23:8]};
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    we_d       = 1'b1;
                    addr_d     = word_cnt_q[ADDR_W-1:0];
                    wdata_d    = {bus.i_byte, wbuf_q};
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == last_q) state_d = S_DONE;
                end
            end
            default: ;
        endcase
        // Release lags DONE by a cycle so the final write lands first.
        done_d     = (state_q == S_DONE);
        core_rst_d = (state_q != S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LEN0;
            len_lo_q   <= '0;
            last_q     <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            wbuf_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            last_q     <= last_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wbuf_q     <= wbuf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_byte_ready = rdy;
    assign bus.o_imem_we    = we_q;
    assign bus.o_imem_addr  = addr_q;
    assign bus.o_imem_wdata = wdata_q;
    assign o_core_rst       = core_rst_q;
    assign o_done           = done_q;
    assign o_err            = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, header errors, full ROM,
// gapped stream, mid-load reset and post-DONE lockout.
module tb_imem_loader;
    localparam int ROM_SIZE = 512;
    localparam int ADDR_W   = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_rst, done, err;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int          p_cyc[$];
    logic [31:0] p_addr[$];
    logic [31:0] p_data[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ROM_SIZE(ROM_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_core_rst (core_rst),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write-pulse log, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.o_imem_we === 1'b1) begin
            p_cyc.push_back(cyc);
            p_addr.push_back(32'(bus.o_imem_addr));
            p_data.push_back(bus.o_imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        p_cyc.delete();
        p_addr.delete();
        p_data.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.o_byte_ready), 32'd0);
        chk("rst_we", 32'(bus.o_imem_we), 32'd0);
        chk("rst_addr", 32'(bus.o_imem_addr), 32'd0);
        chk("rst_wdata", bus.o_imem_wdata, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        clear_log();
        #1 chk("ready_after_rst", 32'(bus.o_byte_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_byte_valid = 1'b1;
        bus.i_byte = b;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        bus.i_byte = 8'($urandom);
        @(posedge clk);
    endtask

    logic [7:0] s1 [10];

    initial begin
        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
        bus.i_byte_valid = 1'b0;
        bus.i_byte = 8'h00;

        // N=2, valid held high
        do_reset();
        for (int i = 0; i < 10; i++) send(s1[i]);
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        chk("s1_last_we", 32'(bus.o_imem_we), 32'd1);
        chk("s1_last_addr", 32'(bus.o_imem_addr), 32'd1);
        chk("s1_last_data", bus.o_imem_wdata, 32'h00108093);
        chk("s1_ready_done", 32'(bus.o_byte_ready), 32'd0);
        chk("s1_done_not_yet", 32'(done), 32'd0);
        chk("s1_core_rst_held", 32'(core_rst), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_core_rel", 32'(core_rst), 32'd0);
        chk("s1_we_off", 32'(bus.o_imem_we), 32'd0);
        chk("s1_npulses", 32'(p_cyc.size()), 32'd2);
        if (p_cyc.size() == 2) begin
            chk("s1_a0", p_addr[0], 32'd0);
            chk("s1_d0", p_data[0], 32'h00000013);
            chk("s1_a1", p_addr[1], 32'd1);
            chk("s1_d1", p_data[1], 32'h00108093);
            chk("s1_gap", 32'(p_cyc[1] - p_cyc[0]), 32'd4);
        end

        // Bytes after DONE are refused
        @(negedge clk);
        bus.i_byte_valid = 1'b1;
        bus.i_byte = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            chk("lock_ready", 32'(bus.o_byte_ready), 32'd0);
            chk("lock_we", 32'(bus.o_imem_we), 32'd0);
            chk("lock_done", 32'(done), 32'd1);
            chk("lock_core_rst", 32'(core_rst), 32'd0);
            chk("lock_wdata", bus.o_imem_wdata, 32'h00108093);
        end
        chk("lock_npulses", 32'(p_cyc.size()), 32'd2);

        // Header 00 00 -> error
        do_reset();
        send(8'h00); send(8'h00);
        @(negedge clk);
        chk("z_err", 32'(err), 32'd1);
        chk("z_ready", 32'(bus.o_byte_ready), 32'd0);
        chk("z_core_rst", 32'(core_rst), 32'd1);
        bus.i_byte = 8'h55;
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        chk("z_err_sticky", 32'(err), 32'd1);
        chk("z_done", 32'(done), 32'd0);
        chk("z_core_rst2", 32'(core_rst), 32'd1);
        chk("z_npulses", 32'(p_cyc.size()), 32'd0);

        // Header 01 02 (N=513) -> error
        do_reset();
        send(8'h01); send(8'h02);
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        chk("big_err", 32'(err), 32'd1);
        chk("big_ready", 32'(bus.o_byte_ready), 32'd0);

        // N=512 fills the ROM
        do_reset();
        send(8'h00); send(8'h02);
        for (int i = 0; i < 512; i++) begin
            send(8'(i)); send(8'(i >> 8)); send(8'hA5); send(8'h3C);
        end
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        chk("full_last_addr", 32'(bus.o_imem_addr), 32'd511);
        chk("full_last_data", bus.o_imem_wdata, 32'h3CA501FF);
        @(posedge clk); @(negedge clk);
        chk("full_done", 32'(done), 32'd1);
        chk("full_npulses", 32'(p_cyc.size()), 32'd512);
        if (p_cyc.size() == 512) begin
            chk("full_a100", p_addr[100], 32'd100);
            chk("full_d100", p_data[100], 32'h3CA50064);
            chk("full_d300", p_data[300], 32'h3CA5012C);
        end

        // Gapped stream with garbage on idle cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(s1[i]);
            idle();
        end
        @(negedge clk);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_npulses", 32'(p_cyc.size()), 32'd2);
        if (p_cyc.size() == 2) begin
            chk("gap_a0", p_addr[0], 32'd0);
            chk("gap_d0", p_data[0], 32'h00000013);
            chk("gap_a1", p_addr[1], 32'd1);
            chk("gap_d1", p_data[1], 32'h00108093);
        end

        // Reset mid-word, then restart
        do_reset();
        send(8'h02); send(8'h00); send(8'hEE); send(8'hDD);
        chk("mid_npulses", 32'(p_cyc.size()), 32'd0);
        do_reset();
        for (int i = 0; i < 10; i++) send(s1[i]);
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_done", 32'(done), 32'd1);
        chk("mid_npulses2", 32'(p_cyc.size()), 32'd2);
        if (p_cyc.size() == 2) begin
            chk("mid_a0", p_addr[0], 32'd0);
            chk("mid_d0", p_data[0], 32'h00000013);
            chk("mid_d1", p_data[1], 32'h00108093);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined RV32I core. Accepts a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into the instruction ROM that the fetch stage reads. Holds the core in reset until the whole program is written, then releases it. Sits between the host byte source (UART receiver or testbench) and the fetch stage's instruction memory write port.

## Interface

Parameters:
- ROM_SIZE, 512: instruction memory depth in 32-bit words; must match the fetch stage ROM.
- ADDR_W, $clog2(ROM_SIZE): width of the word address.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_byte_valid  input  1  source presents a byte.
- i_byte  input  8  byte data.
- o_byte_ready  output  1  loader accepts the byte this cycle. A handshake is valid & ready at a rising edge.
- o_imem_we  output  1  one-cycle write strobe to the instruction memory.
- o_imem_addr  output  ADDR_W  word index (byte address = index*4).
- o_imem_wdata  output  32  assembled instruction word.
- o_core_rst  output  1  reset to the core pipeline. High until the load completes.
- o_done  output  1  program loaded; sticky until rst.
- o_err  output  1  illegal length header; sticky until rst.

## Operation

- Stream format: 16-bit word count N, low byte first, then 4·N data bytes. Each word is little-endian: the first byte goes to [7:0], the fourth to [31:24].
- The FSM has five states.
  - LEN0: ready=1. On handshake, latch len[7:0] and go to LEN1.
  - LEN1: ready=1. On handshake, form N = {i_byte, len_lo}. If N==0 or N>ROM_SIZE, go to ERR. Otherwise go to DATA.
  - DATA: ready=1.
    - Each handshake shifts the byte into the word buffer and increments byte_cnt (2 bits, wraps 3→0).
    - On the handshake where byte_cnt==3, the write is issued and word_cnt increments.
    - If word_cnt==N-1 at that handshake, go to DONE.
  - DONE: ready=0, o_done=1, o_core_rst=0. Stays here until rst.
  - ERR: ready=0, o_err=1, o_core_rst=1. Stays here until rst. Nothing is written.
- When i_byte_valid is low, nothing changes. When ready is low, i_byte is ignored.
- word_cnt is ADDR_W+1 bits wide and compared against N-1. N is 16 bits and is range-checked before any use.
- Reset at any point:
  - state returns to LEN0;
  - byte_cnt, word_cnt, len_lo and the word buffer are cleared;
  - a partially assembled word is discarded;
  - memory already written keeps its contents.

## Timing

- Values during and immediately after rst:
  - o_imem_we=0, o_imem_addr=0, o_imem_wdata=0;
  - o_core_rst=1, o_done=0, o_err=0;
  - o_byte_ready=0 while rst is high, then 1 in the first cycle after rst falls (state LEN0).
- o_byte_ready is combinational from state, gated by ~rst. All other outputs are registered.
- Write latency: the 4th byte of a word is handshaken at edge t. Then o_imem_we=1 for exactly the cycle after t, with addr and wdata stable during that cycle. o_imem_we returns to 0 unless another word completes.
- Throughput is one byte per cycle. DATA keeps ready=1 during a write-strobe cycle, so back-to-back words give a write at most every 4 cycles.
- Completion: the last byte is handshaken at edge t.
  - The cycle after t: state=DONE, ready=0, and the last o_imem_we pulse is high.
  - o_done rises and o_core_rst falls one cycle later, so the final write lands before the core leaves reset.
- Error: the LEN1 handshake is at edge t. The cycle after t: o_err=1 and ready=0.
- Bytes offered in DONE or ERR are never accepted and never produce writes.

## Test plan

- N=2, stream 02 00 13 00 00 00 93 80 10 00 with valid held high.
  - Required: we pulses at addr 0 with 0x00000013, then at addr 1 with 0x00108093, 4 cycles apart.
  - Required: o_done=1 and o_core_rst=0 one cycle after the second pulse.
- Header 00 00.
  - Required: o_err=1 the cycle after the second byte, ready=0, no we pulse, o_core_rst stays 1.
- Header 01 02 (N=513) with ROM_SIZE=512.
  - Required: o_err=1.
- Header 00 02 (N=512) with 2048 data bytes.
  - Required: the last write is to addr 511 and o_done=1.
- Same stream as the first scenario, but valid is low on every other cycle and i_byte is garbage on the idle cycles.
  - Required: identical writes, no extra pulses.
- Header plus 2 data bytes, then rst pulsed for one cycle, then the first scenario's stream restarted.
  - Required: no write before the rst, and addr 0 receives 0x00000013.
- After DONE, drive valid high with byte 0xFF for 10 cycles.
  - Required: ready=0, no we, outputs unchanged.
